// File: rtl/cdc_handshake_rx.sv
// rtl/cdc_handshake_rx.sv - destination-side receiver for a toggle req/ack multi-bit crossing
//
// Purpose:
//   Watches a request toggle that has already been through the two-flop
//   synchronizer. On each toggle it waits SETTLE_CYCLES clocks so the
//   source-held data bus is safe to sample. It then captures the bus and
//   offers the word on a valid/ready interface. When the consumer accepts
//   the word, it flips the acknowledge toggle back towards the source domain
//   and bumps a completed-transfer counter. A request toggle that arrives
//   while a transfer is still open sets a sticky protocol-error flag. That
//   toggle is otherwise dropped.
//
// Ports:
//   clk_dst     in   destination-domain clock
//   sync_reset  in   synchronous active-low reset
//   req_sync    in   request toggle, already synchronized into clk_dst
//   src_bus     in   [DATA_W] source data, held by the source until ack is seen
//   ack_toggle  out  acknowledge toggle back to the source domain
//   dst_valid   out  dst_data holds a captured word
//   dst_data    out  [DATA_W] captured word (holds the last word after handshake)
//   dst_ready   in   consumer accepts the word when high together with dst_valid
//   proto_err   out  sticky: request toggle seen while a transfer was in progress
//   xfer_count  out  [CNT_W] completed transfers, wraps modulo 2^CNT_W

module cdc_handshake_rx #(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic              clk_dst,
  input  logic              sync_reset,
  input  logic              req_sync,
  input  logic [DATA_W-1:0] src_bus,
  output logic              ack_toggle,
  output logic              dst_valid,
  output logic [DATA_W-1:0] dst_data,
  input  logic              dst_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  xfer_count
);

  // The settle counter must hold SETTLE_CYCLES. It keeps at least one bit so
  // that the design stays legal when no settle delay is configured.
  localparam int CNT_BITS = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] SETTLE_INIT = CNT_BITS'(SETTLE_CYCLES);
  localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t              state;
  logic                req_prev;
  logic                req_edge;
  logic [CNT_BITS-1:0] settle_cnt;

  // A change in either direction is a new request (toggle protocol).
  assign req_edge = req_sync ^ req_prev;

  always_ff @(posedge clk_dst) begin
    if (!sync_reset) begin
      state      <= ST_IDLE;
      ack_toggle <= 1'b0;
      dst_valid  <= 1'b0;
      dst_data   <= '0;
      proto_err  <= 1'b0;
      xfer_count <= '0;
      settle_cnt <= '0;
      // Track the current level so a request line left high across reset
      // release is not mistaken for a fresh toggle.
      req_prev   <= req_sync;
    end else begin
      req_prev <= req_sync;

      case (state)
        ST_IDLE: begin
          if (req_edge) begin
            if (SETTLE_CYCLES == 0) begin
              dst_data  <= src_bus;
              dst_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              settle_cnt <= SETTLE_INIT;
              state      <= ST_SETTLE;
            end
          end
        end

        ST_SETTLE: begin
          // The source must not toggle again before it sees our ack. This
          // toggle is only flagged; the open transfer carries on unchanged.
          if (req_edge) begin
            proto_err <= 1'b1;
          end
          if (settle_cnt == SETTLE_LAST) begin
            dst_data  <= src_bus;
            dst_valid <= 1'b1;
            state     <= ST_HOLD;
          end else begin
            settle_cnt <= settle_cnt - SETTLE_LAST;
          end
        end

        ST_HOLD: begin
          // The toggle is flagged even when it lands on the handshake cycle.
          // It is never queued as a follow-up transfer.
          if (req_edge) begin
            proto_err <= 1'b1;
          end
          if (dst_valid && dst_ready) begin
            dst_valid  <= 1'b0;
            ack_toggle <= ~ack_toggle;
            xfer_count <= xfer_count + CNT_W'(1);
            state      <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          dst_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb/tb_cdc_handshake_rx.sv - self-checking bench for cdc_handshake_rx

`timescale 1ns/1ps

module tb_cdc_handshake_rx;

  localparam int SETTLE_A = 2;

  logic        clk;
  int          tests_run;
  int          tests_failed;

  // Instance A: default parameters (SETTLE_CYCLES=2, CNT_W=16)
  logic        rstn_a, req_a, ready_a;
  logic [7:0]  bus_a;
  logic        ack_a, valid_a, err_a;
  logic [7:0]  data_a;
  logic [15:0] cnt_a;

  // Instance B: SETTLE_CYCLES=0, CNT_W=2 for the wrap and zero-latency corner
  logic        rstn_b, req_b, ready_b;
  logic [7:0]  bus_b;
  logic        ack_b, valid_b, err_b;
  logic [7:0]  data_b;
  logic [1:0]  cnt_b;

  // Transaction-level reference: completed transfers and ack parity
  int          m_count;
  bit          m_ack;

  cdc_handshake_rx #(.DATA_W(8), .SETTLE_CYCLES(SETTLE_A), .CNT_W(16)) dut_a (
    .clk_dst(clk), .sync_reset(rstn_a), .req_sync(req_a), .src_bus(bus_a),
    .ack_toggle(ack_a), .dst_valid(valid_a), .dst_data(data_a),
    .dst_ready(ready_a), .proto_err(err_a), .xfer_count(cnt_a)
  );

  cdc_handshake_rx #(.DATA_W(8), .SETTLE_CYCLES(0), .CNT_W(2)) dut_b (
    .clk_dst(clk), .sync_reset(rstn_b), .req_sync(req_b), .src_bus(bus_b),
    .ack_toggle(ack_b), .dst_valid(valid_b), .dst_data(data_b),
    .dst_ready(ready_b), .proto_err(err_b), .xfer_count(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a(input logic req_level);
    req_a   = req_level;
    rstn_a  = 1'b0;
    tick();
    rstn_a  = 1'b1;
    m_count = 0;
    m_ack   = 1'b0;
  endtask

  task automatic test_reset();
    ready_a = 1'b1;
    bus_a   = 8'hFF;
    reset_a(1'b1);
    tests_run++; if (ack_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_ack: got %0b expected 0", ack_a); end
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b expected 0", valid_a); end
    tests_run++; if (data_a !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %0h expected 0", data_a); end
    tests_run++; if (err_a !== 1'b0)   begin tests_failed++; $display("FAIL reset_err: got %0b expected 0", err_a); end
    tests_run++; if (cnt_a !== 16'd0)  begin tests_failed++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
    // A request line held high across reset release must not start a transfer
    for (int i = 0; i < SETTLE_A + 3; i++) begin
      tick();
      tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL reset_no_spurious: cycle %0d valid=%0b expected 0", i, valid_a); end
    end
    reset_a(1'b0);
  endtask

  task automatic test_basic();
    ready_a = 1'b1;
    bus_a   = 8'hA5;
    req_a   = ~req_a;
    for (int i = 1; i <= SETTLE_A; i++) begin
      tick();
      tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL basic_settle: tick %0d valid=%0b expected 0", i, valid_a); end
    end
    tick();
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b expected 1", valid_a); end
    tests_run++; if (data_a !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %0h expected a5", data_a); end
    tests_run++; if (ack_a !== m_ack)  begin tests_failed++; $display("FAIL basic_ack_before: got %0b expected %0b", ack_a, m_ack); end
    tick();
    m_count++; m_ack = ~m_ack;
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL basic_valid_drop: got %0b expected 0", valid_a); end
    tests_run++; if (ack_a !== m_ack)  begin tests_failed++; $display("FAIL basic_ack: got %0b expected %0b", ack_a, m_ack); end
    tests_run++; if (cnt_a !== 16'(m_count)) begin tests_failed++; $display("FAIL basic_count: got %0d expected %0d", cnt_a, m_count); end
    tests_run++; if (data_a !== 8'hA5) begin tests_failed++; $display("FAIL basic_data_hold: got %0h expected a5", data_a); end
  endtask

  task automatic test_backpressure();
    ready_a = 1'b0;
    bus_a   = 8'h3C;
    req_a   = ~req_a;
    repeat (SETTLE_A + 1) tick();
    for (int i = 0; i < 10; i++) begin
      tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL bp_valid: cycle %0d got %0b expected 1", i, valid_a); end
      tests_run++; if (data_a !== 8'h3C) begin tests_failed++; $display("FAIL bp_data: cycle %0d got %0h expected 3c", i, data_a); end
      tests_run++; if (ack_a !== m_ack)  begin tests_failed++; $display("FAIL bp_ack: cycle %0d got %0b expected %0b", i, ack_a, m_ack); end
      tick();
    end
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    m_count++; m_ack = ~m_ack;
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL bp_release_valid: got %0b expected 0", valid_a); end
    tests_run++; if (ack_a !== m_ack)  begin tests_failed++; $display("FAIL bp_release_ack: got %0b expected %0b", ack_a, m_ack); end
    repeat (3) tick();
    tests_run++; if (cnt_a !== 16'(m_count)) begin tests_failed++; $display("FAIL bp_single_count: got %0d expected %0d", cnt_a, m_count); end
    tests_run++; if (ack_a !== m_ack)  begin tests_failed++; $display("FAIL bp_single_ack: got %0b expected %0b", ack_a, m_ack); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    logic [7:0] seen  [$];
    words[0] = 8'h11;
    words[1] = 8'h22;
    reset_a(1'b0);
    ready_a = 1'b1;
    for (int w = 0; w < 2; w++) begin
      bus_a = words[w];
      req_a = ~req_a;
      // Collect whatever appears on the valid/ready interface, bounded in time
      for (int c = 0; c < SETTLE_A + 4; c++) begin
        tick();
        if (valid_a === 1'b1) seen.push_back(data_a);
        if (ack_a !== m_ack) break;
      end
      m_count++; m_ack = ~m_ack;
      tests_run++; if (ack_a !== m_ack) begin tests_failed++; $display("FAIL b2b_ack_%0d: got %0b expected %0b", w, ack_a, m_ack); end
    end
    tests_run++; if (seen.size() !== 2) begin tests_failed++; $display("FAIL b2b_words: got %0d words expected 2", seen.size()); end
    for (int w = 0; w < 2 && w < seen.size(); w++) begin
      tests_run++; if (seen[w] !== words[w]) begin tests_failed++; $display("FAIL b2b_order_%0d: got %0h expected %0h", w, seen[w], words[w]); end
    end
    tests_run++; if (ack_a !== 1'b0)  begin tests_failed++; $display("FAIL b2b_ack_final: got %0b expected 0", ack_a); end
    tests_run++; if (cnt_a !== 16'd2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", cnt_a); end
    tests_run++; if (err_a !== 1'b0)  begin tests_failed++; $display("FAIL b2b_err: got %0b expected 0", err_a); end
  endtask

  task automatic test_violation();
    // Second toggle while the first word is waiting in HOLD
    reset_a(1'b0);
    ready_a = 1'b0;
    bus_a   = 8'h5A;
    req_a   = ~req_a;
    repeat (SETTLE_A + 1) tick();
    bus_a   = 8'hC3;
    req_a   = ~req_a;
    tick();
    tests_run++; if (err_a !== 1'b1)   begin tests_failed++; $display("FAIL viol_err: got %0b expected 1", err_a); end
    tests_run++; if (data_a !== 8'h5A) begin tests_failed++; $display("FAIL viol_data: got %0h expected 5a", data_a); end
    ready_a = 1'b1;
    tick();
    ready_a = 1'b0;
    m_count++; m_ack = ~m_ack;
    tests_run++; if (ack_a !== m_ack) begin tests_failed++; $display("FAIL viol_ack: got %0b expected %0b", ack_a, m_ack); end
    for (int i = 0; i < SETTLE_A + 3; i++) begin
      tick();
      tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL viol_no_queue: cycle %0d valid=%0b expected 0", i, valid_a); end
    end
    tests_run++; if (err_a !== 1'b1) begin tests_failed++; $display("FAIL viol_sticky: got %0b expected 1", err_a); end
    tests_run++; if (cnt_a !== 16'(m_count)) begin tests_failed++; $display("FAIL viol_count: got %0d expected %0d", cnt_a, m_count); end
    tests_run++; if (ack_a !== m_ack) begin tests_failed++; $display("FAIL viol_one_ack: got %0b expected %0b", ack_a, m_ack); end

    // Toggle during SETTLE: flagged, transfer still completes with the held word
    reset_a(1'b0);
    ready_a = 1'b0;
    bus_a   = 8'h96;
    req_a   = ~req_a;
    tick();
    req_a   = ~req_a;
    repeat (SETTLE_A) tick();
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL viol_settle_valid: got %0b expected 1", valid_a); end
    tests_run++; if (data_a !== 8'h96) begin tests_failed++; $display("FAIL viol_settle_data: got %0h expected 96", data_a); end
    tests_run++; if (err_a !== 1'b1)   begin tests_failed++; $display("FAIL viol_settle_err: got %0b expected 1", err_a); end

    // Toggle on the handshake cycle: handshake completes, error set, nothing queued
    reset_a(1'b0);
    ready_a = 1'b0;
    bus_a   = 8'h77;
    req_a   = ~req_a;
    repeat (SETTLE_A + 1) tick();
    ready_a = 1'b1;
    req_a   = ~req_a;
    tick();
    ready_a = 1'b0;
    m_count++; m_ack = ~m_ack;
    tests_run++; if (ack_a !== m_ack) begin tests_failed++; $display("FAIL viol_hs_ack: got %0b expected %0b", ack_a, m_ack); end
    tests_run++; if (err_a !== 1'b1)  begin tests_failed++; $display("FAIL viol_hs_err: got %0b expected 1", err_a); end
    repeat (SETTLE_A + 3) tick();
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL viol_hs_no_queue: got %0b expected 0", valid_a); end
  endtask

  task automatic test_reset_mid_hold();
    reset_a(1'b0);
    ready_a = 1'b0;
    bus_a   = 8'hE7;
    req_a   = 1'b1;
    repeat (SETTLE_A + 1) tick();
    tests_run++; if (valid_a !== 1'b1) begin tests_failed++; $display("FAIL rmh_pre_valid: got %0b expected 1", valid_a); end
    rstn_a = 1'b0;
    tick();
    rstn_a = 1'b1;
    tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL rmh_valid: got %0b expected 0", valid_a); end
    tests_run++; if (data_a !== 8'h00) begin tests_failed++; $display("FAIL rmh_data: got %0h expected 0", data_a); end
    tests_run++; if (ack_a !== 1'b0)   begin tests_failed++; $display("FAIL rmh_ack: got %0b expected 0", ack_a); end
    tests_run++; if (cnt_a !== 16'd0)  begin tests_failed++; $display("FAIL rmh_count: got %0d expected 0", cnt_a); end
    ready_a = 1'b1;
    for (int i = 0; i < SETTLE_A + 3; i++) begin
      tick();
      tests_run++; if (valid_a !== 1'b0 || ack_a !== 1'b0) begin tests_failed++; $display("FAIL rmh_no_spurious: cycle %0d valid=%0b ack=%0b expected 0 0", i, valid_a, ack_a); end
    end
    reset_a(req_a);
  endtask

  task automatic test_random();
    logic [7:0] word;
    int         gap, delay;
    ready_a = 1'b0;
    for (int t = 0; t < 25; t++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) tick();
      word  = 8'($urandom);
      bus_a = word;
      req_a = ~req_a;
      for (int i = 0; i < SETTLE_A; i++) begin
        tick();
        tests_run++; if (valid_a !== 1'b0) begin tests_failed++; $display("FAIL rand_settle: xfer %0d tick %0d valid=%0b expected 0", t, i, valid_a); end
      end
      tick();
      tests_run++; if (valid_a !== 1'b1 || data_a !== word) begin tests_failed++; $display("FAIL rand_capture: xfer %0d valid=%0b data=%0h expected 1 %0h", t, valid_a, data_a, word); end
      delay = $urandom_range(0, 4);
      for (int d = 0; d < delay; d++) begin
        tick();
        tests_run++; if (valid_a !== 1'b1 || data_a !== word || ack_a !== m_ack) begin tests_failed++; $display("FAIL rand_hold: xfer %0d valid=%0b data=%0h ack=%0b expected 1 %0h %0b", t, valid_a, data_a, ack_a, word, m_ack); end
      end
      ready_a = 1'b1;
      tick();
      ready_a = 1'b0;
      m_count++; m_ack = ~m_ack;
      tests_run++; if (valid_a !== 1'b0 || ack_a !== m_ack || cnt_a !== 16'(m_count)) begin tests_failed++; $display("FAIL rand_handshake: xfer %0d valid=%0b ack=%0b count=%0d expected 0 %0b %0d", t, valid_a, ack_a, cnt_a, m_ack, m_count); end
    end
    tests_run++; if (err_a !== 1'b0) begin tests_failed++; $display("FAIL rand_err: got %0b expected 0", err_a); end
  endtask

  task automatic test_wrap();
    logic [7:0] word;
    int         expected;
    req_b   = 1'b0;
    ready_b = 1'b1;
    bus_b   = 8'h00;
    rstn_b  = 1'b0;
    tick();
    rstn_b  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      word  = 8'($urandom);
      bus_b = word;
      req_b = ~req_b;
      tick();
      tests_run++; if (valid_b !== 1'b1 || data_b !== word) begin tests_failed++; $display("FAIL wrap_zero_latency: xfer %0d valid=%0b data=%0h expected 1 %0h", k, valid_b, data_b, word); end
      tick();
      expected = k % 4;
      tests_run++; if (cnt_b !== 2'(expected)) begin tests_failed++; $display("FAIL wrap_count: xfer %0d got %0d expected %0d", k, cnt_b, expected); end
      tests_run++; if (ack_b !== 1'(k % 2)) begin tests_failed++; $display("FAIL wrap_ack: xfer %0d got %0b expected %0b", k, ack_b, k % 2); end
    end
    tests_run++; if (err_b !== 1'b0) begin tests_failed++; $display("FAIL wrap_err: got %0b expected 0", err_b); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rstn_a = 1'b0; req_a = 1'b0; ready_a = 1'b0; bus_a = 8'h00;
    rstn_b = 1'b0; req_b = 1'b0; ready_b = 1'b0; bus_b = 8'h00;
    m_count = 0;
    m_ack   = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_violation();
    test_reset_mid_hold();
    test_random();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
